key_repeat: RTL
===============

KEY_REPEAT -- requirements
Module: key_repeat

Interface
REQ-001 Parameter FIRST_MS, default 8'd200: hold time in ms before the first auto-repeat; legal range 1..255.
REQ-002 Parameter REPEAT_MS, default 8'd80: period in ms between subsequent repeats; legal range 1..255.
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  reset: rst, synchronous, active-high; clock clk.
REQ-005 btn  input  4  raw buttons, bit0 up, bit1 down, bit2 left, bit3 right; 1 = pressed.
REQ-006 delay_free  input  1  from the downstream ms-delay timer; 1 = timer expired or idle.
REQ-007 move_ready  input  1  move consumer accepts move this cycle.
REQ-008 delay_set  output  1  one-cycle pulse that loads the ms-delay timer.
REQ-009 delay_ms  output  8  load value for the timer; valid when delay_set = 1.
REQ-010 move_valid  output  1  move request pending.
REQ-011 move_dir  output  2  move direction: 0 up, 1 down, 2 left, 3 right.

Function
REQ-012 Active direction = lowest-index set bit of the (synchronised) btn; none = released.
REQ-013 FSM states: IDLE, EMIT, ARM, WAIT; all registered.
REQ-014 IDLE: on a pressed button, latch its direction and go to EMIT next cycle; move_valid = 1 in the first EMIT cycle.
REQ-015 EMIT: move_valid = 1 and move_dir = latched direction, both held stable until move_valid & move_ready.
REQ-016 EMIT: a release or direction change does not drop a pending move_valid.
REQ-017 On acceptance: if the latched direction is still held, delay_set = 1 for exactly one cycle with delay_ms = FIRST_MS after the first move, REPEAT_MS after any repeat; state moves to ARM.
REQ-018 On acceptance with the latched direction no longer held: no delay_set; state moves to IDLE.
REQ-019 ARM lasts exactly one cycle and ignores delay_free, since the timer drops free only one cycle after the load; then WAIT.
REQ-020 WAIT: if the active direction differs from the latched one or is none, go to IDLE next cycle; this check has priority over delay_free.
REQ-021 WAIT: if delay_free = 1 and the latched direction is still active, go to EMIT as a repeat.
REQ-022 delay_set is never asserted outside the ARM entry cycle; delay_ms = 0 whenever delay_set = 0.
REQ-023 Latency from visible press to move_valid: 1 cycle, plus synchroniser latency (REQ-026).

Reset
REQ-024 rst: state IDLE, move_valid 0, move_dir 0, delay_set 0, delay_ms 0, synchroniser flops 0.
REQ-025 rst in any state, including a pending EMIT, discards the move and the outstanding timer ownership; the next cycle is IDLE.

Configuration
REQ-026 INPUT_SYNC_EN defined: btn passes through a 2-flop synchroniser, adding 2 cycles of press and release latency.
REQ-027 INPUT_SYNC_EN undefined: btn is used directly, with no added latency; inputs must already be synchronous to clk.

Structure
REQ-028 Shared package maze_input_pkg SHALL hold the direction codes (DIR_UP..DIR_RIGHT), the FSM state encoding, and the default FIRST_MS/REPEAT_MS constants.
REQ-029 Sub-module btn_sync, a 4-bit 2-flop synchroniser, SHALL be instantiated only under INPUT_SYNC_EN.
REQ-030 The ms-delay timer is external; key_repeat connects to it only through delay_set, delay_ms and delay_free.

Verification
REQ-031 Press right, move_ready = 1, no sync -> move_valid 1 cycle later with dir 3; delay_set pulse with delay_ms = 200 on the cycle after acceptance.
REQ-032 Hold up 1 s with a real timer (FIRST_MS = 200, REPEAT_MS = 80) -> moves at ~0, 200, 280, 360 ... ms, with delay_ms 200 then 80 on each pulse.
REQ-033 Press left with move_ready = 0 for 5 cycles, release in cycle 2 -> move_valid held with dir 2 until ready; no delay_set afterwards; state returns to IDLE.
REQ-034 Press up+right together -> dir 0; release up while waiting -> IDLE, then a new first move with dir 3 and delay_ms = 200.
REQ-035 delay_free forced high through ARM -> no repeat in the ARM cycle; repeat emitted only from WAIT.
REQ-036 Assert rst during WAIT and during a pending EMIT -> all outputs 0 on the next cycle; no delay_set.

Source files
------------

// File: rtl/maze_input_pkg.sv
// -----------------------------------------------------------------------------
// maze_input_pkg
// Shared definitions for the maze input path: direction codes, the key_repeat
// FSM state encoding, default hold/repeat delays in ms, and the priority
// encoder that turns the button vector into an active direction.
// -----------------------------------------------------------------------------
package maze_input_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_ARM  = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    localparam logic [7:0] FIRST_MS_DEFAULT  = 8'd200;
    localparam logic [7:0] REPEAT_MS_DEFAULT = 8'd80;

    typedef struct packed {
        logic pressed;
        dir_t dir;
    } active_t;

    // Lowest-index pressed button wins; dir is don't-care when nothing is pressed.
    function automatic active_t active_dir(input logic [3:0] btn);
        active_t a;
        a.pressed = |btn;
        a.dir     = DIR_UP;
        if (btn[0])      a.dir = DIR_UP;
        else if (btn[1]) a.dir = DIR_DOWN;
        else if (btn[2]) a.dir = DIR_LEFT;
        else if (btn[3]) a.dir = DIR_RIGHT;
        return a;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// -----------------------------------------------------------------------------
// btn_sync
// 4-bit two-flop synchroniser for the raw buttons. Adds two cycles of latency
// to both press and release. Only used when INPUT_SYNC_EN is defined.
//
// Ports
//   clk     system clock
//   rst     synchronous active-high reset, clears both flop stages
//   raw     asynchronous button inputs
//   synced  buttons synchronised to clk
// -----------------------------------------------------------------------------
module btn_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] raw,
    output logic [3:0] synced
);

    logic [3:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= '0;
            synced <= '0;
        end else begin
            meta   <= raw;
            synced <= meta;
        end
    end

endmodule

// File: rtl/key_repeat.sv
// -----------------------------------------------------------------------------
// key_repeat
// Turns held direction buttons into move requests with keyboard-style
// auto-repeat: one move on press, another after FIRST_MS, then one every
// REPEAT_MS while the same direction stays active. The ms timer lives outside;
// this block loads it with delay_set/delay_ms and polls delay_free.
//
// Build option
//   INPUT_SYNC_EN  defined: btn goes through btn_sync (2 cycles extra latency)
//                  undefined: btn must already be synchronous to clk
//
// Parameters
//   FIRST_MS   hold time before the first repeat, 1..255 ms
//   REPEAT_MS  period between later repeats, 1..255 ms
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   btn         buttons: bit0 up, bit1 down, bit2 left, bit3 right; 1 = pressed
//   delay_free  timer expired or idle
//   move_ready  consumer accepts the move this cycle
//   delay_set   one-cycle timer load pulse
//   delay_ms    timer load value, 0 whenever delay_set is 0
//   move_valid  move request pending
//   move_dir    move direction: 0 up, 1 down, 2 left, 3 right
// -----------------------------------------------------------------------------
module key_repeat
    import maze_input_pkg::*;
#(
    parameter logic [7:0] FIRST_MS  = FIRST_MS_DEFAULT,
    parameter logic [7:0] REPEAT_MS = REPEAT_MS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic       delay_free,
    input  logic       move_ready,
    output logic       delay_set,
    output logic [7:0] delay_ms,
    output logic       move_valid,
    output logic [1:0] move_dir
);

    logic [3:0] btn_s;

`ifdef INPUT_SYNC_EN
    btn_sync u_btn_sync (
        .clk    (clk),
        .rst    (rst),
        .raw    (btn),
        .synced (btn_s)
    );
`else
    assign btn_s = btn;
`endif

    active_t act;
    state_t  state;
    dir_t    dir_q;
    logic    first_q;   // the move in flight is the initial press, not a repeat
    logic    held;

    assign act      = active_dir(btn_s);
    assign held     = act.pressed && (act.dir == dir_q);
    assign move_dir = dir_q;

    // NOTE: every flop here, including the state register, is cleared by the
    // synchronous reset; a pending move and any timer ownership are simply dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            dir_q      <= DIR_UP;
            first_q    <= 1'b0;
            move_valid <= 1'b0;
            delay_set  <= 1'b0;
            delay_ms   <= '0;
        end else begin
            // NOTE: non-blocking defaults first, so the load pulse lasts one
            // cycle unless the EMIT branch below overrides it.
            delay_set <= 1'b0;
            delay_ms  <= '0;
            case (state)
                ST_IDLE: begin
                    if (act.pressed) begin
                        dir_q      <= act.dir;
                        first_q    <= 1'b1;
                        move_valid <= 1'b1;
                        state      <= ST_EMIT;
                    end
                end
                // move_valid is high throughout EMIT; release while pending
                // only decides what happens after acceptance.
                ST_EMIT: begin
                    if (move_ready) begin
                        move_valid <= 1'b0;
                        if (held) begin
                            delay_set <= 1'b1;
                            delay_ms  <= first_q ? FIRST_MS : REPEAT_MS;
                            state     <= ST_ARM;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                // The timer only drops delay_free a cycle after the load, so
                // a stale "free" would be seen here; skip it.
                ST_ARM: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!held) begin
                        state <= ST_IDLE;
                    end else if (delay_free) begin
                        first_q    <= 1'b0;
                        move_valid <= 1'b1;
                        state      <= ST_EMIT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
